// File: rtl/mutative_reconfig_sequencer_if.sv
// Connection bundle for the reconfiguration sequencer: setup handshake, cache array
// access and the memory-side writeback port. "master" is the sequencer side.
interface mutative_reconfig_sequencer_if #(
    parameter int SET_BITS = 4,
    parameter int WAY_BITS = 3,
    parameter int TAG_BITS = 23,
    parameter int WB_BITS  = 8
);
    logic [1:0]          setup_req;
    logic                setup_req_valid;
    logic                setup_req_ready;
    logic [1:0]          setup;
    logic                cache_idle;
    logic                hold;
    logic                flush_active;
    logic                arr_rd;
    logic                arr_inval;
    logic [SET_BITS-1:0] arr_set;
    logic [WAY_BITS-1:0] arr_way;
    logic                arr_valid;
    logic                arr_dirty;
    logic [TAG_BITS-1:0] arr_tag;
    logic [255:0]        arr_data;
    logic [31:0]         dfp_addr;
    logic                dfp_write;
    logic [255:0]        dfp_wdata;
    logic                dfp_resp;
    logic                flush_done;
    logic [WB_BITS-1:0]  wb_count;

    modport master (
        input  setup_req, setup_req_valid, cache_idle,
        input  arr_valid, arr_dirty, arr_tag, arr_data, dfp_resp,
        output setup_req_ready, setup, hold, flush_active,
        output arr_rd, arr_inval, arr_set, arr_way,
        output dfp_addr, dfp_write, dfp_wdata, flush_done, wb_count
    );

    modport slave (
        output setup_req, setup_req_valid, cache_idle,
        output arr_valid, arr_dirty, arr_tag, arr_data, dfp_resp,
        input  setup_req_ready, setup, hold, flush_active,
        input  arr_rd, arr_inval, arr_set, arr_way,
        input  dfp_addr, dfp_write, dfp_wdata, flush_done, wb_count
    );
endinterface

// File: rtl/mutative_reconfig_sequencer.sv
// Reconfigures cache associativity: stalls the CPU side, drains the cache, writes back
// dirty lines, invalidates every set/way and then commits the new setup.
module mutative_reconfig_sequencer #(
    parameter int         WAYS        = 8,
    parameter int         SETS        = 16,
    parameter int         SET_BITS    = 4,
    parameter int         TAG_BITS    = 23,
    parameter int         OFFSET_BITS = 5,
    parameter logic [1:0] RESET_SETUP = 2'b11
) (
    input logic                          clk,
    input logic                          rst,
    mutative_reconfig_sequencer_if.master bus
);
    localparam int WAY_BITS = $clog2(WAYS);
    localparam int WB_BITS  = $clog2(SETS * WAYS) + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_READ   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_WB     = 3'd4,
        ST_INVAL  = 3'd5,
        ST_COMMIT = 3'd6
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           setup_q, pending_q;
    logic [SET_BITS-1:0]  set_q;
    logic [WAY_BITS-1:0]  way_q;
    logic [WB_BITS-1:0]   wb_count_q;
    logic [31:0]          dfp_addr_q;
    logic [255:0]         dfp_wdata_q;
    logic ready_q, hold_q, active_q, rd_q, inval_q, write_q, done_q;
    logic ready_d, hold_d, active_d, rd_d, inval_d, write_d, done_d;
    logic start_s, dirty_s, last_line_s, last_way_s;

    assign start_s     = bus.setup_req_valid && ready_q && (bus.setup_req != setup_q);
    assign dirty_s     = bus.arr_valid && bus.arr_dirty;
    assign last_way_s  = (way_q == WAY_BITS'(WAYS - 1));
    assign last_line_s = last_way_s && (set_q == SET_BITS'(SETS - 1));

    // State register and registered control outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            hold_q   <= 1'b0;
            active_q <= 1'b0;
            rd_q     <= 1'b0;
            inval_q  <= 1'b0;
            write_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            hold_q   <= hold_d;
            active_q <= active_d;
            rd_q     <= rd_d;
            inval_q  <= inval_d;
            write_q  <= write_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_s) state_d = ST_DRAIN; else state_d = ST_IDLE;
            ST_DRAIN:  if (bus.cache_idle) state_d = ST_READ; else state_d = ST_DRAIN;
            ST_READ:   state_d = ST_CHECK;
            ST_CHECK:  if (dirty_s) state_d = ST_WB; else state_d = ST_INVAL;
            ST_WB:     if (bus.dfp_resp) state_d = ST_INVAL; else state_d = ST_WB;
            ST_INVAL:  if (last_line_s) state_d = ST_COMMIT; else state_d = ST_READ;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Control outputs decoded from the next state so they register in step with it
    always_comb begin
        ready_d  = 1'b0;
        hold_d   = 1'b0;
        active_d = 1'b0;
        rd_d     = 1'b0;
        inval_d  = 1'b0;
        write_d  = 1'b0;
        done_d   = 1'b0;
        case (state_d)
            ST_IDLE:   ready_d = 1'b1;
            ST_DRAIN:  hold_d  = 1'b1;
            ST_READ:   begin hold_d = 1'b1; active_d = 1'b1; rd_d    = 1'b1; end
            ST_CHECK:  begin hold_d = 1'b1; active_d = 1'b1; end
            ST_WB:     begin hold_d = 1'b1; active_d = 1'b1; write_d = 1'b1; end
            ST_INVAL:  begin hold_d = 1'b1; active_d = 1'b1; inval_d = 1'b1; end
            ST_COMMIT: begin hold_d = 1'b1; active_d = 1'b1; done_d  = 1'b1; end
            default:   ready_d = 1'b0;
        endcase
    end

    // Walk pointer, pending/committed setup and writeback capture
    always_ff @(posedge clk) begin
        if (rst) begin
            setup_q     <= RESET_SETUP;
            pending_q   <= RESET_SETUP;
            set_q       <= {SET_BITS{1'b0}};
            way_q       <= {WAY_BITS{1'b0}};
            wb_count_q  <= {WB_BITS{1'b0}};
            dfp_addr_q  <= 32'd0;
            dfp_wdata_q <= 256'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        pending_q  <= bus.setup_req;
                        wb_count_q <= {WB_BITS{1'b0}};
                    end
                end
                ST_DRAIN: begin
                    set_q <= {SET_BITS{1'b0}};
                    way_q <= {WAY_BITS{1'b0}};
                end
                ST_CHECK: begin
                    if (dirty_s) begin
                        dfp_addr_q  <= {bus.arr_tag, set_q, {OFFSET_BITS{1'b0}}};
                        dfp_wdata_q <= bus.arr_data;
                        wb_count_q  <= wb_count_q + WB_BITS'(1'b1);
                    end
                end
                ST_INVAL: begin
                    // Way is the inner loop so each set is finished before moving on
                    if (!last_line_s) begin
                        if (last_way_s) begin
                            way_q <= {WAY_BITS{1'b0}};
                            set_q <= set_q + SET_BITS'(1'b1);
                        end else begin
                            way_q <= way_q + WAY_BITS'(1'b1);
                        end
                    end
                end
                ST_COMMIT: setup_q <= pending_q;
                default:   setup_q <= setup_q;
            endcase
        end
    end

    assign bus.setup_req_ready = ready_q;
    assign bus.setup           = setup_q;
    assign bus.hold            = hold_q;
    assign bus.flush_active    = active_q;
    assign bus.arr_rd          = rd_q;
    assign bus.arr_inval       = inval_q;
    assign bus.arr_set         = set_q;
    assign bus.arr_way         = way_q;
    assign bus.dfp_addr        = dfp_addr_q;
    assign bus.dfp_write       = write_q;
    assign bus.dfp_wdata       = dfp_wdata_q;
    assign bus.flush_done      = done_q;
    assign bus.wb_count        = wb_count_q;
endmodule

// File: tb/tb_mutative_reconfig_sequencer.sv
// Randomized bench for the reconfiguration sequencer with a line-level cache/memory model.
module tb_mutative_reconfig_sequencer;
    localparam int WAYS = 8, SETS = 16, SET_BITS = 4, WAY_BITS = 3, TAG_BITS = 23;
    localparam int WB_BITS = 8, LINES = SETS * WAYS;

    logic clk;
    logic rst;
    int   n_tests, n_fail;

    mutative_reconfig_sequencer_if #(.SET_BITS(SET_BITS), .WAY_BITS(WAY_BITS),
        .TAG_BITS(TAG_BITS), .WB_BITS(WB_BITS)) bus ();

    mutative_reconfig_sequencer #(.WAYS(WAYS), .SETS(SETS), .SET_BITS(SET_BITS),
        .TAG_BITS(TAG_BITS), .OFFSET_BITS(5), .RESET_SETUP(2'b11)) dut (
        .clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cache contents and per-line memory response delay
    bit                  m_v [LINES];
    bit                  m_d [LINES];
    logic [TAG_BITS-1:0] m_t [LINES];
    logic [255:0]        m_data [LINES];
    int                  m_wait [LINES];

    logic [31:0]  exp_addr_q [$];
    logic [255:0] exp_data_q [$];
    int           exp_wait_q [$];

    int inval_idx, wb_idx, wb_cyc, fd_count;
    logic [1:0] cur;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // environment: arrays with read data ready in the following cycle, memory responder
    always @(negedge clk) begin
        int l;
        if (rst) begin
            bus.arr_valid = 1'b0;
            bus.arr_dirty = 1'b0;
            bus.arr_tag   = '0;
            bus.arr_data  = '0;
            bus.dfp_resp  = 1'b0;
            wb_cyc        = 0;
        end else begin
            if (bus.arr_rd) begin
                l = int'({bus.arr_set, bus.arr_way});
                bus.arr_valid = m_v[l];
                bus.arr_dirty = m_d[l];
                bus.arr_tag   = m_t[l];
                bus.arr_data  = m_data[l];
            end
            if (bus.arr_inval) begin
                l = int'({bus.arr_set, bus.arr_way});
                check("inval_order", l, inval_idx);
                inval_idx++;
                m_v[l] = 1'b0;
                m_d[l] = 1'b0;
            end
            if (bus.flush_active) check("hold_in_flush", bus.hold, 1);
            if (bus.flush_done) fd_count++;
            if (bus.dfp_write) begin
                wb_cyc++;
                if (wb_idx < exp_addr_q.size()) begin
                    check("wb_addr", bus.dfp_addr, exp_addr_q[wb_idx]);
                    check("wb_data", bus.dfp_wdata, exp_data_q[wb_idx]);
                    bus.dfp_resp = (wb_cyc == exp_wait_q[wb_idx] + 1);
                end else begin
                    check("wb_extra", 1, 0);
                    bus.dfp_resp = 1'b1;
                end
                if (bus.dfp_resp) wb_idx++;
            end else begin
                wb_cyc       = 0;
                bus.dfp_resp = 1'b0;
            end
        end
    end

    task automatic fill(input bit with_dirty);
        for (int l = 0; l < LINES; l++) begin
            m_v[l]    = bit'($urandom_range(0, 1));
            m_d[l]    = with_dirty && ($urandom_range(0, 3) == 0);
            m_t[l]    = TAG_BITS'($urandom);
            for (int w = 0; w < 8; w++) m_data[l][32*w +: 32] = $urandom;
            m_wait[l] = $urandom_range(0, 5);
        end
    endtask

    task automatic build_expect(output int extra);
        logic [3:0] s;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_wait_q.delete();
        extra = 0;
        for (int l = 0; l < LINES; l++) begin
            if (m_v[l] && m_d[l]) begin
                s = 4'(l / WAYS);
                exp_addr_q.push_back({m_t[l], s, 5'b00000});
                exp_data_q.push_back(m_data[l]);
                exp_wait_q.push_back(m_wait[l]);
                extra += 1 + m_wait[l];
            end
        end
    endtask

    task automatic run_flush(input logic [1:0] req, input int drain, input bit midreq);
        int   extra, exp_lat, first_rd, n_wb;
        bit   got;
        build_expect(extra);
        n_wb      = exp_addr_q.size();
        exp_lat   = 3 * LINES + 2 + drain + extra;
        inval_idx = 0;
        wb_idx    = 0;
        fd_count  = 0;
        first_rd  = 0;
        got       = 1'b0;
        @(negedge clk);
        bus.cache_idle = (drain == 0);
        check("ready_idle", bus.setup_req_ready, 1);
        bus.setup_req       = req;
        bus.setup_req_valid = 1'b1;
        @(posedge clk);
        #1;
        check("hold_next", bus.hold, 1);
        for (int k = 1; k <= exp_lat + 100 && !got; k++) begin
            @(negedge clk);
            if (k == 1) bus.setup_req_valid = 1'b0;
            if (k == drain + 1) bus.cache_idle = 1'b1;
            if (midreq && k == 60) begin
                bus.setup_req       = ~req;
                bus.setup_req_valid = 1'b1;
            end
            if (midreq && k == 61) bus.setup_req_valid = 1'b0;
            @(posedge clk);
            #1;
            if (midreq && k == 60) check("ready_mid", bus.setup_req_ready, 0);
            if (k <= drain) begin
                check("drain_hold", bus.hold, 1);
                check("drain_no_rd", bus.arr_rd, 0);
            end
            if (bus.arr_rd && first_rd == 0) first_rd = k;
            if (bus.setup != cur) begin
                got = 1'b1;
                check("commit_edge", k, exp_lat);
                check("setup_val", bus.setup, req);
            end
        end
        if (!got) check("commit_timeout", 0, 1);
        check("first_rd", first_rd, drain + 1);
        repeat (2) @(posedge clk);
        #1;
        check("flush_done_cnt", fd_count, 1);
        check("wb_count", bus.wb_count, n_wb);
        check("wb_seen", wb_idx, n_wb);
        check("inval_cnt", inval_idx, LINES);
        check("ready_after", bus.setup_req_ready, 1);
        check("hold_after", bus.hold, 0);
        cur = req;
    endtask

    initial begin
        logic [1:0] r;
        int e;
        n_tests             = 0;
        n_fail              = 0;
        rst                 = 1'b1;
        bus.setup_req       = 2'b00;
        bus.setup_req_valid = 1'b0;
        bus.cache_idle      = 1'b1;
        cur                 = 2'b11;
        for (int l = 0; l < LINES; l++) begin
            m_v[l] = 1'b0; m_d[l] = 1'b0; m_t[l] = '0; m_data[l] = '0; m_wait[l] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_setup", bus.setup, 2'b11);
        check("rst_ready", bus.setup_req_ready, 1);
        check("rst_hold", bus.hold, 0);
        check("rst_active", bus.flush_active, 0);
        check("rst_wbcount", bus.wb_count, 0);
        check("rst_dfpw", bus.dfp_write, 0);
        check("rst_addr", bus.dfp_addr, 0);
        check("rst_rd_inval", {bus.arr_rd, bus.arr_inval, bus.flush_done}, 0);
        @(negedge clk);
        rst = 1'b0;

        // request equal to current setup: accepted, nothing happens
        bus.setup_req       = 2'b11;
        bus.setup_req_valid = 1'b1;
        fd_count            = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("same_ready", bus.setup_req_ready, 1);
            check("same_hold", bus.hold, 0);
            check("same_setup", bus.setup, 2'b11);
        end
        @(negedge clk);
        bus.setup_req_valid = 1'b0;
        check("same_no_done", fd_count, 0);

        fill(1'b0);
        run_flush(2'b00, 0, 1'b0);

        // single dirty line at set5/way3, memory answers after 4 waiting cycles
        fill(1'b0);
        e = 5 * WAYS + 3;
        m_v[e] = 1'b1; m_d[e] = 1'b1; m_t[e] = 23'h12345; m_wait[e] = 4;
        for (int w = 0; w < 8; w++) m_data[e][32*w +: 32] = 32'hC0DE_0000 + 32'(w);
        run_flush(2'b01, 0, 1'b0);

        fill(1'b1);
        run_flush(2'b10, 10, 1'b0);

        fill(1'b1);
        run_flush(2'b11, 0, 1'b1);

        for (int t = 0; t < 3; t++) begin
            r = 2'($urandom_range(0, 3));
            if (r == cur) r = r + 2'b01;
            fill(1'b1);
            run_flush(r, $urandom_range(0, 5), 1'b0);
        end

        // reset while a writeback is in flight
        fill(1'b0);
        m_v[0] = 1'b1; m_d[0] = 1'b1; m_wait[0] = 30;
        build_expect(e);
        inval_idx = 0;
        wb_idx    = 0;
        @(negedge clk);
        bus.setup_req       = ~cur;
        bus.setup_req_valid = 1'b1;
        @(negedge clk);
        bus.setup_req_valid = 1'b0;
        for (int k = 0; k < 20 && !bus.dfp_write; k++) @(negedge clk);
        check("wb_reached", bus.dfp_write, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstwb_dfpw", bus.dfp_write, 0);
        check("rstwb_hold", bus.hold, 0);
        check("rstwb_setup", bus.setup, 2'b11);
        check("rstwb_ready", bus.setup_req_ready, 1);
        check("rstwb_active", bus.flush_active, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/mutative_reconfig_sequencer.md
Name: mutative_reconfig_sequencer

Overview:
- Sequences associativity changes of the mutative cache.
- When the setup controller requests a new `setup`, this block:
  - stalls new CPU requests;
  - waits for the cache FSM to go idle;
  - walks every set/way, writing back dirty lines to memory and invalidating every line;
  - commits the new `setup`.
- Sits between the setup controller, the tag/data/valid arrays and the memory-side (dfp) port. The top level muxes array and dfp control to this block while `flush_active`=1.

Parameters:
- WAYS, 8, physical ways.
- SETS, 16, sets per way.
- SET_BITS, 4, log2(SETS).
- TAG_BITS, 23, stored tag width (dirty bit carried separately).
- OFFSET_BITS, 5, line offset bits (32-byte line).
- RESET_SETUP, 2'b11, setup after reset (0=DM, 1=2-way, 2=4-way, 3=8-way).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- setup_req  in  2  requested setup
- setup_req_valid  in  1  request strobe
- setup_req_ready  out  1  request accepted when valid&ready
- setup  out  2  committed setup, drives cache indexing and PLRU
- cache_idle  in  1  cache FSM idle, no outstanding ufp/dfp transaction
- hold  out  1  cache must not accept new ufp requests
- flush_active  out  1  this block owns arrays and dfp port
- arr_rd  out  1  read all arrays of arr_way at arr_set (1-cycle SRAM latency)
- arr_inval  out  1  write valid=0, dirty=0 to arr_way at arr_set
- arr_set  out  SET_BITS  set index
- arr_way  out  log2(WAYS)  way index
- arr_valid  in  1  valid bit read
- arr_dirty  in  1  dirty bit read
- arr_tag  in  TAG_BITS  tag read
- arr_data  in  256  line read
- dfp_addr  out  32  writeback address
- dfp_write  out  1  writeback request
- dfp_wdata  out  256  writeback data
- dfp_resp  in  1  memory response
- flush_done  out  1  one-cycle pulse on commit
- wb_count  out  log2(SETS*WAYS)+1  dirty writebacks in the last flush

Behaviour:
- Reset values:
  - state=IDLE, `setup`=RESET_SETUP, `wb_count`=0.
  - `setup_req_ready`=1.
  - All other outputs 0; dfp_addr, dfp_wdata and arr_* indices 0.
- Reset mid-flush aborts immediately with no writeback completion. Safe because the cache valid arrays reset in the same cycle.
- Handshake:
  - `setup_req_ready`=1 only in IDLE.
  - On valid&ready with setup_req≠setup: latch pending, clear `wb_count`, go to DRAIN.
  - On valid&ready with setup_req==setup: accept, no action, no `flush_done`.
- FSM:
  - IDLE: wait for a request.
  - DRAIN:
    - `hold`=1.
    - Stay while `cache_idle`=0.
    - Go to READ with set=0, way=0.
  - READ:
    - `hold`=1, `flush_active`=1, `arr_rd`=1 for the current set/way.
    - Go to CHECK.
  - CHECK:
    - Sample arr_*.
    - If `arr_valid`&`arr_dirty`: register dfp_addr={arr_tag, set, OFFSET_BITS'0} and dfp_wdata=arr_data, increment `wb_count`, go to WB.
    - Otherwise go to INVAL.
  - WB:
    - `dfp_write`=1 with addr/data held stable until `dfp_resp`.
    - On `dfp_resp`, go to INVAL; `dfp_write` drops the next cycle.
  - INVAL:
    - `arr_inval`=1 for one cycle.
    - If way==WAYS-1 and set==SETS-1, go to COMMIT.
    - Otherwise advance way, wrapping to 0 and incrementing set; go to READ.
  - COMMIT:
    - `setup`<=pending at end of cycle.
    - `flush_done`=1 this cycle.
    - Go to IDLE.
- `hold`=1 and `flush_active`=1 in READ..COMMIT. `hold`=1 in DRAIN.
- Every line is invalidated, including clean and invalid lines, because the set/way mapping changes with `setup`.
- Latency, `cache_idle`=1 and no dirty lines: `setup` changes 3*SETS*WAYS+2 edges after the handshake edge (386 for defaults).
  - Each dirty line adds 1 + (cycles until `dfp_resp`).
- `setup_req_valid` during a flush is ignored (ready=0); the requester must hold or retry.
- `dfp_resp` outside WB is ignored.
- `wb_count` holds its value until the next accepted, differing request.

Test Plan:
- Reset; `setup_req`=2'b11, valid → `setup` stays 3, `setup_req_ready` stays 1, no `hold`, no `flush_done`.
- All lines clean, `cache_idle`=1, request 2'b00 → `hold` next cycle; `setup`=0 exactly 386 edges after the handshake; `flush_done` pulses once; 128 `arr_inval` pulses in order set0/way0..set15/way7; `wb_count`=0.
- Set5/way3 valid+dirty with tag 0x12345 and data pattern, memory responds after 4 cycles → dfp_write held 4 cycles with dfp_addr={0x12345,4'd5,5'd0} and matching dfp_wdata; `wb_count`=1; commit at 386+5.
- `cache_idle`=0 for 10 cycles after the request → stays in DRAIN with `hold`=1 and no `arr_rd`; first `arr_rd` 1 cycle after `cache_idle` rises.
- New `setup_req_valid` mid-flush → `setup_req_ready`=0, request ignored; original pending `setup` commits.
- Assert `rst` during WB → next cycle `dfp_write`=0, `hold`=0, `setup`=RESET_SETUP, state IDLE.
